// File: rtl/regfile.sv
// 32 x DATA_W integer register file: two combinational read ports, one synchronous write port.
// x0 is hardwired to zero. A debug port reads stored values without bypass.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_wren,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q     [1:NUM_REGS-1];
    logic [DATA_W-1:0] mem_d     [1:NUM_REGS-1];
    logic [DATA_W-1:0] regs_view [0:NUM_REGS-1];
    logic              byp_rs1;
    logic              byp_rs2;

    always_comb begin
        mem_d = mem_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (!i_rst_n) begin
                mem_d[i] = '0;
            end else if (i_rd_wren && (i_rd_addr == ADDR_W'(i))) begin
                mem_d[i] = i_rd_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Index 0 is a constant zero so every port can use a plain array lookup.
    always_comb begin
        regs_view[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_view[i] = mem_q[i];
        end
    end

    always_comb begin
        byp_rs1 = (BYPASS != 0) && i_rd_wren && (i_rd_addr == i_rs1_addr);
        byp_rs2 = (BYPASS != 0) && i_rd_wren && (i_rd_addr == i_rs2_addr);
    end

    // Outputs are forced low during reset so nothing uninitialised escapes before the first edge.
    always_comb begin
        o_rs1_data = '0;
        o_rs2_data = '0;
        o_dbg_data = '0;
        if (i_rst_n) begin
            if (i_rs1_addr != '0) begin
                o_rs1_data = byp_rs1 ? i_rd_data : regs_view[i_rs1_addr];
            end
            if (i_rs2_addr != '0) begin
                o_rs2_data = byp_rs2 ? i_rd_data : regs_view[i_rs2_addr];
            end
            o_dbg_data = regs_view[i_dbg_addr];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed and model-checked bench for regfile; one instance with bypass, one without,
// driven by the same stimulus.
module tb_regfile;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wren;
    logic [4:0]  dbg_addr;
    logic [31:0] b_rs1, b_rs2, b_dbg;
    logic [31:0] n_rs1, n_rs2, n_dbg;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [0:31];
    logic [31:0] exp_b1, exp_b2, exp_n1, exp_n2, exp_dbg;

    regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_byp (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (b_rs1),
        .o_rs2_data (b_rs2),
        .i_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .i_rd_wren  (rd_wren),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (b_dbg)
    );

    regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_nobyp (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_data (n_rs1),
        .o_rs2_data (n_rs2),
        .i_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .i_rd_wren  (rd_wren),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (n_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic wren, input logic [4:0] rd,
                         input logic [31:0] data, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] ad);
        rst_n    = rst;
        rd_wren  = wren;
        rd_addr  = rd;
        rd_data  = data;
        rs1_addr = a1;
        rs2_addr = a2;
        dbg_addr = ad;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held from time 0: outputs must already be zero before any edge.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd5);
        chk("pre_edge_rs1", b_rs1, 32'h0);
        chk("pre_edge_rs2", b_rs2, 32'h0);
        chk("pre_edge_dbg", b_dbg, 32'h0);
        next_cycle();

        // Reset clear
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
        chk("wr_x5_nobyp_old", n_rs1, 32'h0);
        chk("wr_x5_byp_fwd", b_rs1, 32'hDEADBEEF);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        chk("x5_stored", b_rs1, 32'hDEADBEEF);
        chk("x5_stored_dbg", n_dbg, 32'hDEADBEEF);
        drive(1'b0, 1'b1, 5'd6, 32'h11111111, 5'd5, 5'd6, 5'd5);
        chk("in_reset_rs1", b_rs1, 32'h0);
        chk("in_reset_rs2_byp", b_rs2, 32'h0);
        chk("in_reset_dbg", n_dbg, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, 5'd5);
        chk("after_reset_x5", b_rs1, 32'h0);
        chk("reset_write_dropped_x6", n_rs2, 32'h0);
        chk("after_reset_dbg_x5", b_dbg, 32'h0);

        // Basic write/read
        drive(1'b1, 1'b1, 5'd1, 32'h12345678, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd31, 32'h0, 5'd1, 5'd31, 5'd31);
        chk("basic_rs1_x1", n_rs1, 32'h12345678);
        chk("basic_rs2_x31", n_rs2, 32'hFFFFFFFF);
        chk("basic_dbg_x31", b_dbg, 32'hFFFFFFFF);
        chk("wren0_no_fwd", b_rs2, 32'hFFFFFFFF);

        // x0 hardwire
        drive(1'b1, 1'b1, 5'd0, 32'hA5A5A5A5, 5'd0, 5'd0, 5'd0);
        chk("x0_wcyc_byp_rs1", b_rs1, 32'h0);
        chk("x0_wcyc_byp_rs2", b_rs2, 32'h0);
        chk("x0_wcyc_dbg", b_dbg, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        chk("x0_later_rs1", b_rs1, 32'h0);
        chk("x0_later_rs2", n_rs2, 32'h0);
        chk("x0_later_dbg", n_dbg, 32'h0);

        // Bypass vs no bypass
        drive(1'b1, 1'b1, 5'd7, 32'h1, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 1'b1, 5'd7, 32'h2, 5'd7, 5'd7, 5'd7);
        chk("byp_rs1", b_rs1, 32'h2);
        chk("byp_rs2", b_rs2, 32'h2);
        chk("byp_dbg_old", b_dbg, 32'h1);
        chk("nobyp_rs1_old", n_rs1, 32'h1);
        chk("nobyp_rs2_old", n_rs2, 32'h1);
        next_cycle();
        drive(1'b1, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7);
        chk("byp_after_rs1", b_rs1, 32'h2);
        chk("byp_after_dbg", b_dbg, 32'h2);
        chk("nobyp_after_rs1", n_rs1, 32'h2);
        chk("nobyp_after_rs2", n_rs2, 32'h2);

        // Last write wins on back-to-back writes
        drive(1'b1, 1'b1, 5'd9, 32'hAAAA0001, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, 1'b1, 5'd9, 32'hBBBB0002, 5'd9, 5'd1, 5'd9);
        chk("b2b_mid_nobyp", n_rs1, 32'hAAAA0001);
        chk("b2b_mid_byp", b_rs1, 32'hBBBB0002);
        chk("b2b_other_port", b_rs2, 32'h12345678);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
        chk("b2b_final", n_rs1, 32'hBBBB0002);
        chk("b2b_final_dbg", b_dbg, 32'hBBBB0002);

        // Random regression against a reference array; start from a known cleared state.
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        next_cycle();
        for (int k = 0; k < 32; k++) mem_m[k] = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (($urandom_range(0, 7) == 0)) begin
                rs1_addr = rd_addr;
                rs2_addr = rd_addr;
                #1;
            end
            exp_n1  = rst_n ? mem_m[rs1_addr] : 32'h0;
            exp_n2  = rst_n ? mem_m[rs2_addr] : 32'h0;
            exp_dbg = rst_n ? mem_m[dbg_addr] : 32'h0;
            exp_b1  = exp_n1;
            exp_b2  = exp_n2;
            if (rst_n && rd_wren && rd_addr != 5'd0 && rs1_addr == rd_addr) exp_b1 = rd_data;
            if (rst_n && rd_wren && rd_addr != 5'd0 && rs2_addr == rd_addr) exp_b2 = rd_data;
            chk("rnd_byp_rs1", b_rs1, exp_b1);
            chk("rnd_byp_rs2", b_rs2, exp_b2);
            chk("rnd_byp_dbg", b_dbg, exp_dbg);
            chk("rnd_nobyp_rs1", n_rs1, exp_n1);
            chk("rnd_nobyp_rs2", n_rs2, exp_n2);
            chk("rnd_nobyp_dbg", n_dbg, exp_dbg);
            if (!rst_n) begin
                for (int k = 0; k < 32; k++) mem_m[k] = 32'h0;
            end else if (rd_wren && rd_addr != 5'd0) begin
                mem_m[rd_addr] = rd_data;
            end
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
